// File: rtl/glb_access_arbiter_if.sv
// Requester-side and GLB-side signal bundle for glb_access_arbiter.
// master = the arbiter; slave = FIFO controllers plus the GLB macro.
interface glb_access_arbiter_if #(
    parameter int NUM_IF = 32,
    parameter int NUM_IP = 32,
    parameter int NUM_OP = 32,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // req/permit handshake: a requester holds req and its payload stable until it sees its
    // permit bit high in the same cycle; a permitted access is taken unconditionally.
    logic [NUM_IF-1:0]             ifmap_glb_read_req_i;
    logic [NUM_IF-1:0][ADDR_W-1:0] ifmap_glb_read_addr_i;
    logic [NUM_IP-1:0]             ipsum_glb_read_req_i;
    logic [NUM_IP-1:0][ADDR_W-1:0] ipsum_glb_read_addr_i;
    logic [NUM_OP-1:0]             opsum_glb_write_req_i;
    logic [NUM_OP-1:0][ADDR_W-1:0] opsum_glb_write_addr_i;
    logic [NUM_OP-1:0][DATA_W-1:0] opsum_glb_write_data_i;
    logic [NUM_OP-1:0][3:0]        opsum_glb_write_web_i;
    logic [NUM_IF-1:0]             ifmap_permit_push_o;
    logic [NUM_IP-1:0]             ipsum_permit_push_o;
    logic [NUM_OP-1:0]             opsum_permit_pop_o;
    logic                          glb_en_o;
    logic                          glb_we_o;
    logic [3:0]                    glb_web_o;
    logic [ADDR_W-1:0]             glb_addr_o;
    logic [DATA_W-1:0]             glb_wdata_o;
    logic [DATA_W-1:0]             glb_rdata_i;
    logic                          rdata_valid_o;
    logic [1:0]                    rdata_class_o;
    logic [4:0]                    rdata_idx_o;
    logic [DATA_W-1:0]             rdata_o;

    modport master (
        input  ifmap_glb_read_req_i, ifmap_glb_read_addr_i,
        input  ipsum_glb_read_req_i, ipsum_glb_read_addr_i,
        input  opsum_glb_write_req_i, opsum_glb_write_addr_i,
        input  opsum_glb_write_data_i, opsum_glb_write_web_i,
        input  glb_rdata_i,
        output ifmap_permit_push_o, ipsum_permit_push_o, opsum_permit_pop_o,
        output glb_en_o, glb_we_o, glb_web_o, glb_addr_o, glb_wdata_o,
        output rdata_valid_o, rdata_class_o, rdata_idx_o, rdata_o
    );

    modport slave (
        output ifmap_glb_read_req_i, ifmap_glb_read_addr_i,
        output ipsum_glb_read_req_i, ipsum_glb_read_addr_i,
        output opsum_glb_write_req_i, opsum_glb_write_addr_i,
        output opsum_glb_write_data_i, opsum_glb_write_web_i,
        output glb_rdata_i,
        input  ifmap_permit_push_o, ipsum_permit_push_o, opsum_permit_pop_o,
        input  glb_en_o, glb_we_o, glb_web_o, glb_addr_o, glb_wdata_o,
        input  rdata_valid_o, rdata_class_o, rdata_idx_o, rdata_o
    );
endinterface

// File: rtl/glb_access_arbiter.sv
// Single-port GLB arbiter: opsum > ifmap > ipsum, round-robin within each class, tagged read return.
// Define GLB_ARB_STARVE_GUARD_EN to let starving ifmap/ipsum classes jump to top priority.
module glb_access_arbiter #(
    parameter int NUM_IF       = 32,
    parameter int NUM_IP       = 32,
    parameter int NUM_OP       = 32,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 16
) (
    input logic clk,
    input logic rst,
    glb_access_arbiter_if.master bus
);
    localparam int IDX_W = 5;

    typedef enum logic [1:0] {
        CLS_NONE = 2'b00,
        CLS_IF   = 2'b01,
        CLS_IP   = 2'b10,
        CLS_OP   = 2'b11
    } cls_e;

    logic [IDX_W-1:0]  ptr_if, ptr_ip, ptr_op;
    logic [IDX_W-1:0]  win_if, win_ip, win_op, win_idx;
    logic              hit_if, hit_ip, hit_op;
    logic              starve_if, starve_ip;
    logic [ADDR_W-1:0] win_addr;
    cls_e              win_cls;
    logic              s1_valid;
    logic [1:0]        s1_cls;
    logic [IDX_W-1:0]  s1_idx;

    // First asserted request at or after ptr, wrapping; smallest offset wins.
    function automatic logic [IDX_W:0] rr_find(input logic [31:0] req, input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] pos;
        rr_find = '0;
        for (int i = 31; i >= 0; i--) begin
            pos = ptr + IDX_W'(i);
            if (req[pos]) rr_find = {1'b1, pos};
        end
    endfunction

    function automatic logic [IDX_W-1:0] ptr_next(input logic [IDX_W-1:0] w, input int n);
        return (int'(w) == n - 1) ? '0 : w + 1'b1;
    endfunction

    assign {hit_if, win_if} = rr_find(32'(bus.ifmap_glb_read_req_i), ptr_if);
    assign {hit_ip, win_ip} = rr_find(32'(bus.ipsum_glb_read_req_i), ptr_ip);
    assign {hit_op, win_op} = rr_find(32'(bus.opsum_glb_write_req_i), ptr_op);

`ifdef GLB_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] cnt_if, cnt_ip;

    assign starve_if = hit_if && (cnt_if >= CNT_W'(STARVE_LIMIT));
    assign starve_ip = hit_ip && (cnt_ip >= CNT_W'(STARVE_LIMIT));

    // Counters saturate at the limit and stay there until their class wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_if <= '0;
            cnt_ip <= '0;
        end else begin
            if (win_cls == CLS_IF)          cnt_if <= '0;
            else if (hit_if && !starve_if)  cnt_if <= cnt_if + 1'b1;
            if (win_cls == CLS_IP)          cnt_ip <= '0;
            else if (hit_ip && !starve_ip)  cnt_ip <= cnt_ip + 1'b1;
        end
    end
`else
    logic starve_cfg_unused;
    assign starve_cfg_unused = (STARVE_LIMIT != 0);
    assign starve_if = 1'b0;
    assign starve_ip = 1'b0;
`endif

    always_comb begin
        win_cls  = CLS_NONE;
        win_idx  = '0;
        win_addr = '0;
        bus.ifmap_permit_push_o = '0;
        bus.ipsum_permit_push_o = '0;
        bus.opsum_permit_pop_o  = '0;
        if (rst)            win_cls = CLS_NONE;
        else if (starve_if) win_cls = CLS_IF;
        else if (starve_ip) win_cls = CLS_IP;
        else if (hit_op)    win_cls = CLS_OP;
        else if (hit_if)    win_cls = CLS_IF;
        else if (hit_ip)    win_cls = CLS_IP;
        case (win_cls)
            CLS_IF: begin
                win_idx  = win_if;
                win_addr = bus.ifmap_glb_read_addr_i[win_if];
                bus.ifmap_permit_push_o[win_if] = 1'b1;
            end
            CLS_IP: begin
                win_idx  = win_ip;
                win_addr = bus.ipsum_glb_read_addr_i[win_ip];
                bus.ipsum_permit_push_o[win_ip] = 1'b1;
            end
            CLS_OP: begin
                win_idx  = win_op;
                win_addr = bus.opsum_glb_write_addr_i[win_op];
                bus.opsum_permit_pop_o[win_op] = 1'b1;
            end
            default: ;
        endcase
    end

    // Command register, read tag stage 1 and stage 2; reset drops any in-flight read tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_if            <= '0;
            ptr_ip            <= '0;
            ptr_op            <= '0;
            bus.glb_en_o      <= 1'b0;
            bus.glb_we_o      <= 1'b0;
            bus.glb_web_o     <= 4'b0000;
            bus.glb_addr_o    <= '0;
            bus.glb_wdata_o   <= '0;
            s1_valid          <= 1'b0;
            s1_cls            <= 2'b00;
            s1_idx            <= '0;
            bus.rdata_valid_o <= 1'b0;
            bus.rdata_class_o <= 2'b00;
            bus.rdata_idx_o   <= '0;
        end else begin
            case (win_cls)
                CLS_IF:  ptr_if <= ptr_next(win_if, NUM_IF);
                CLS_IP:  ptr_ip <= ptr_next(win_ip, NUM_IP);
                CLS_OP:  ptr_op <= ptr_next(win_op, NUM_OP);
                default: ;
            endcase
            bus.glb_en_o    <= (win_cls != CLS_NONE);
            bus.glb_we_o    <= (win_cls == CLS_OP);
            bus.glb_web_o   <= (win_cls == CLS_OP) ? bus.opsum_glb_write_web_i[win_op] : 4'b0000;
            bus.glb_wdata_o <= (win_cls == CLS_OP) ? bus.opsum_glb_write_data_i[win_op] : '0;
            bus.glb_addr_o  <= win_addr;
            s1_valid        <= (win_cls == CLS_IF) || (win_cls == CLS_IP);
            s1_cls          <= ((win_cls == CLS_IF) || (win_cls == CLS_IP)) ? win_cls : 2'b00;
            s1_idx          <= ((win_cls == CLS_IF) || (win_cls == CLS_IP)) ? win_idx : '0;
            bus.rdata_valid_o <= s1_valid;
            bus.rdata_class_o <= s1_cls;
            bus.rdata_idx_o   <= s1_idx;
        end
    end

    // GLB data arrives one cycle after the command, aligned with the stage-2 tag.
    assign bus.rdata_o = bus.rdata_valid_o ? bus.glb_rdata_i : '0;
endmodule
